// File: rtl/var_delay_pkg.sv
// Shared helpers for the variable-length delay chain.
package var_delay_pkg;

   // Map a requested delay onto the legal tap range 1..max_len.
   function automatic int dly_clamp(input int d, input int max_len);
      if (d < 1) return 1;
      if (d > max_len) return max_len;
      return d;
   endfunction

endpackage

// File: rtl/var_delay_stage.sv
// One register stage of the delay chain: CH x DW data word plus a valid bit.
module var_delay_stage
   import var_delay_pkg::*;
#(
   parameter int DW = 8,
   parameter int CH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr_valid,
   input  logic [CH-1:0][DW-1:0]  d_data,
   input  logic                   d_valid,
   output logic [CH-1:0][DW-1:0]  q_data,
   output logic                   q_valid
);

   // Data advances only on enabled edges; valid also clears on a disabled
   // clear, while an enabled edge always captures the incoming valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_data  <= '0;
         q_valid <= 1'b0;
      end else begin
         if (en) begin
            q_data  <= d_data;
            q_valid <= d_valid;
         end else if (clr_valid) begin
            q_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/var_delay_chain.sv
// Multi-channel delay line with run-time selectable tap, stall, flush and
// fill tracking. Output is a mux over stage registers (no extra latency).
module var_delay_chain
   import var_delay_pkg::*;
#(
   parameter  int DW      = 8,
   parameter  int CH      = 2,
   parameter  int MAX_LEN = 8,
   localparam int DLYW    = $clog2(MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   flush,
   input  logic [DLYW-1:0]        dly,
   input  logic                   in_valid,
   input  logic [CH-1:0][DW-1:0]  in,
   output logic                   out_valid,
   output logic [CH-1:0][DW-1:0]  out,
   output logic                   primed
);

   logic [CH-1:0][DW-1:0] st_data [1:MAX_LEN];
   logic [MAX_LEN:1]      st_valid;

   logic [DLYW-1:0] dly_q;
   logic [DLYW-1:0] fill_cnt;
   logic [DLYW-1:0] dly_eff_q;
   logic [DLYW-1:0] dly_eff_in;
   logic            dly_change;
   logic            clr;

   assign dly_eff_q  = DLYW'(dly_clamp(int'(dly_q), MAX_LEN));
   assign dly_eff_in = DLYW'(dly_clamp(int'(dly), MAX_LEN));

   // Only a change of the clamped delay matters; raw values that clamp to
   // the same tap keep the stream intact.
   assign dly_change = (dly_eff_in != dly_eff_q);
   assign clr        = flush | dly_change;

   // Stage 1 always takes the live input so a word presented on a clearing
   // edge survives; deeper stages drop their incoming valid on a clear.
   for (genvar k = 1; k <= MAX_LEN; k++) begin : g_stage
      logic [CH-1:0][DW-1:0] d_data;
      logic                  d_valid;

      if (k == 1) begin : g_first
         assign d_data  = in;
         assign d_valid = in_valid;
      end else begin : g_rest
         assign d_data  = st_data[k-1];
         assign d_valid = st_valid[k-1] & ~clr;
      end

      var_delay_stage #(
         .DW (DW),
         .CH (CH)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .clr_valid (clr),
         .d_data    (d_data),
         .d_valid   (d_valid),
         .q_data    (st_data[k]),
         .q_valid   (st_valid[k])
      );
   end

   // Registered delay selection and saturating fill counter.
   // dly_q follows dly only on enabled edges; a pending change seen while
   // stalled keeps clearing until the next enabled edge commits it.
   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q    <= '0;
         fill_cnt <= '0;
      end else begin
         if (en) dly_q <= dly;
         if (clr) begin
            fill_cnt <= en ? DLYW'(1) : '0;
         end else if (en && (fill_cnt < DLYW'(MAX_LEN))) begin
            fill_cnt <= fill_cnt + DLYW'(1);
         end
      end
   end

   // Output tap selected by the registered, clamped delay.
   always_comb begin
      out       = '0;
      out_valid = 1'b0;
      for (int unsigned k = 1; k <= MAX_LEN; k++) begin
         if (DLYW'(k) == dly_eff_q) begin
            out       = st_data[k];
            out_valid = st_valid[k];
         end
      end
   end

   assign primed = (fill_cnt >= dly_eff_q);

endmodule

// File: tb/tb_var_delay_chain.sv
// Directed bench for var_delay_chain (DW=8, CH=2, MAX_LEN=8).
module tb_var_delay_chain;

   localparam int DW      = 8;
   localparam int CH      = 2;
   localparam int MAX_LEN = 8;
   localparam int DLYW    = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst, en, flush, in_valid, out_valid, primed;
   logic [DLYW-1:0]       dly;
   logic [CH-1:0][DW-1:0] din, dout;

   int tests = 0;
   int fails = 0;

   var_delay_chain #(
      .DW      (DW),
      .CH      (CH),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .dly       (dly),
      .in_valid  (in_valid),
      .in        (din),
      .out_valid (out_valid),
      .out       (dout),
      .primed    (primed)
   );

   function automatic logic [15:0] word(input int v);
      return {8'(v), 8'(v + 100)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input int v);
      chk({tag, "_ov"}, 32'(out_valid), 32'd1);
      chk({tag, "_out"}, 32'(dout), 32'(word(v)));
   endtask

   task automatic drive(input int v, input logic vld);
      din      = word(v);
      in_valid = vld;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; flush = 1'b0; dly = 4'd3; in_valid = 1'b0; din = '0;
      repeat (3) tick;
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_out", 32'(dout), 32'd0);
      chk("rst_primed", 32'(primed), 32'd0);

      // 1: first word at dly=3
      rst = 1'b0; din = 16'hA53C; in_valid = 1'b1;
      tick;
      chk("t1_e1_ov", 32'(out_valid), 32'd0);
      chk("t1_e1_primed", 32'(primed), 32'd0);
      in_valid = 1'b0; din = '0;
      tick;
      chk("t1_e2_ov", 32'(out_valid), 32'd0);
      chk("t1_e2_primed", 32'(primed), 32'd0);
      tick;
      chk("t1_e3_ov", 32'(out_valid), 32'd1);
      chk("t1_e3_out", 32'(dout), 32'hA53C);
      chk("t1_e3_primed", 32'(primed), 32'd1);
      tick;
      chk("t1_e4_ov", 32'(out_valid), 32'd0);

      // 2: clamping, dly=0 -> 1
      dly = 4'd0;
      for (int j = 0; j < 32; j++) begin
         drive(j, 1'b1);
         tick;
         chk_word($sformatf("t2a_%0d", j), j);
      end
      // dly=15 -> 8, then 9 and 12 (same clamp, no flush)
      dly = 4'd15;
      for (int j = 0; j < 32; j++) begin
         if (j == 20) dly = 4'd9;
         if (j == 25) dly = 4'd12;
         drive(j, 1'b1);
         tick;
         if (j >= 7) chk_word($sformatf("t2b_%0d", j), j - 7);
         else        chk($sformatf("t2b_ov_%0d", j), 32'(out_valid), 32'd0);
         chk($sformatf("t2b_primed_%0d", j), 32'(primed), (j >= 7) ? 32'd1 : 32'd0);
      end

      // 3: stall at dly=4
      dly = 4'd4;
      for (int j = 0; j < 10; j++) begin
         drive(j + 1, 1'b1);
         tick;
         if (j >= 3) chk_word($sformatf("t3a_%0d", j), j - 2);
         else        chk($sformatf("t3a_ov_%0d", j), 32'(out_valid), 32'd0);
      end
      en = 1'b0; din = 16'hEEEE; in_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick;
         chk_word($sformatf("t3_stall_%0d", j), 7);
         chk($sformatf("t3_stall_primed_%0d", j), 32'(primed), 32'd1);
      end
      en = 1'b1;
      for (int j = 10; j < 20; j++) begin
         drive(j + 1, 1'b1);
         tick;
         chk_word($sformatf("t3b_%0d", j), j - 2);
      end

      // 4: delay change 2 -> 5 mid-stream
      dly = 4'd2;
      for (int j = 0; j < 16; j++) begin
         if (j == 6) dly = 4'd5;
         drive(10 + j, 1'b1);
         tick;
         if (j < 6) begin
            if (j >= 1) chk_word($sformatf("t4a_%0d", j), 10 + j - 1);
            else        chk("t4a_ov_0", 32'(out_valid), 32'd0);
         end else if (j < 10) begin
            chk($sformatf("t4_gap_ov_%0d", j), 32'(out_valid), 32'd0);
            chk($sformatf("t4_gap_primed_%0d", j), 32'(primed), 32'd0);
         end else begin
            chk_word($sformatf("t4b_%0d", j), 10 + j - 4);
            chk($sformatf("t4b_primed_%0d", j), 32'(primed), 32'd1);
         end
      end

      // 5: flush with en=1 at dly=3
      dly = 4'd3;
      for (int j = 0; j < 6; j++) begin
         drive(40 + j, 1'b1);
         tick;
         if (j >= 2) chk_word($sformatf("t5a_%0d", j), 40 + j - 2);
      end
      flush = 1'b1; din = 16'h7711; in_valid = 1'b1;
      tick;
      flush = 1'b0;
      chk("t5_f0_ov", 32'(out_valid), 32'd0);
      chk("t5_f0_primed", 32'(primed), 32'd0);
      in_valid = 1'b0; din = '0;
      tick;
      chk("t5_f1_ov", 32'(out_valid), 32'd0);
      tick;
      chk("t5_f2_ov", 32'(out_valid), 32'd1);
      chk("t5_f2_out", 32'(dout), 32'h7711);
      tick;
      chk("t5_f3_ov", 32'(out_valid), 32'd0);
      // flush with en=0
      for (int j = 0; j < 5; j++) begin
         drive(60 + j, 1'b1);
         tick;
         if (j >= 2) chk_word($sformatf("t5b_%0d", j), 60 + j - 2);
      end
      en = 1'b0; flush = 1'b1; drive(99, 1'b1);
      tick;
      chk("t5_g0_ov", 32'(out_valid), 32'd0);
      chk("t5_g0_primed", 32'(primed), 32'd0);
      flush = 1'b0;
      tick;
      chk("t5_g1_ov", 32'(out_valid), 32'd0);
      en = 1'b1; in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick;
         chk($sformatf("t5_idle_ov_%0d", j), 32'(out_valid), 32'd0);
      end
      din = 16'h99AA; in_valid = 1'b1;
      tick;
      in_valid = 1'b0; din = '0;
      chk("t5_h1_ov", 32'(out_valid), 32'd0);
      tick;
      chk("t5_h2_ov", 32'(out_valid), 32'd0);
      tick;
      chk("t5_h3_ov", 32'(out_valid), 32'd1);
      chk("t5_h3_out", 32'(dout), 32'h99AA);

      // 6: reset mid-operation at dly=6
      dly = 4'd6;
      for (int j = 0; j < 10; j++) begin
         drive(j, 1'b1);
         tick;
         if (j >= 5) chk_word($sformatf("t6a_%0d", j), j - 5);
      end
      rst = 1'b1; flush = 1'b1; en = 1'b1; drive(200, 1'b1);
      tick;
      chk("t6_rst_out", 32'(dout), 32'd0);
      chk("t6_rst_ov", 32'(out_valid), 32'd0);
      chk("t6_rst_primed", 32'(primed), 32'd0);
      rst = 1'b0; flush = 1'b0; din = 16'hC35A; in_valid = 1'b1;
      tick;
      chk("t6_e1_ov", 32'(out_valid), 32'd0);
      in_valid = 1'b0; din = '0;
      for (int k = 2; k <= 6; k++) begin
         tick;
         if (k < 6) begin
            chk($sformatf("t6_e%0d_ov", k), 32'(out_valid), 32'd0);
         end else begin
            chk("t6_e6_ov", 32'(out_valid), 32'd1);
            chk("t6_e6_out", 32'(dout), 32'hC35A);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
